// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port register file with two write ports, optional
//             write-to-read bypass and a per-register busy scoreboard with
//             an outstanding-reservation counter. Register 0 reads as zero.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  output logic [NUM_RD-1:0]        RdBusy,
  input  logic                     WrEn0,
  input  logic [ADDR_W-1:0]        WrAddr0,
  input  logic [DATA_W-1:0]        WrData0,
  input  logic                     WrEn1,
  input  logic [ADDR_W-1:0]        WrAddr1,
  input  logic [DATA_W-1:0]        WrData1,
  input  logic                     RsvEn,
  input  logic [ADDR_W-1:0]        RsvAddr,
  output logic                     RsvAck,
  output logic [ADDR_W:0]          BusyCnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wr0_v, wr1_v, rsv_same, cnt_inc, cnt_dec;

  // Writes to index 0 are never effective on either port.
  assign wr0_v    = WrEn0 && (WrAddr0 != '0);
  assign wr1_v    = WrEn1 && (WrAddr1 != '0);
  // A port-1 write retiring the register being reserved in the same cycle
  // frees it, so the new reservation is accepted regardless of busy_q.
  assign rsv_same = wr1_v && (WrAddr1 == RsvAddr);

  assign RsvAck  = !RST && RsvEn && (RsvAddr != '0) &&
                   (!busy_q[RsvAddr] || rsv_same);
  assign BusyCnt = cnt_q;

  // Counter tracks the population of busy_q: grows only when a clear bit
  // becomes set, shrinks only when a set bit is cleared and not re-reserved.
  assign cnt_inc = RsvAck && !busy_q[RsvAddr];
  assign cnt_dec = wr1_v && busy_q[WrAddr1] && !(RsvAck && rsv_same);

  // Next-state for storage, scoreboard and counter; port 1 overrides port 0.
  always_comb begin
    mem_d = mem_q;
    if (wr0_v) mem_d[WrAddr0] = WrData0;
    if (wr1_v) mem_d[WrAddr1] = WrData1;
    mem_d[0] = '0;

    busy_d = busy_q;
    if (wr1_v)  busy_d[WrAddr1] = 1'b0;
    if (RsvAck) busy_d[RsvAddr] = 1'b1;
    busy_d[0] = 1'b0;

    cnt_d = cnt_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdata;
    logic              rbusy;

    assign ra = RdAddr[k*ADDR_W +: ADDR_W];

    // Read mux: port-1 bypass, then port-0 bypass, then storage; zero in reset.
    always_comb begin
      rdata = mem_q[ra];
      rbusy = busy_q[ra];
      if ((BYPASS != 0) && wr1_v && (WrAddr1 == ra)) begin
        rdata = WrData1;
        rbusy = 1'b0;
      end else if ((BYPASS != 0) && wr0_v && (WrAddr0 == ra)) begin
        rdata = WrData0;
      end
      if (RST) begin
        rdata = '0;
        rbusy = 1'b0;
      end
    end

    assign RdData[k*DATA_W +: DATA_W] = rdata;
    assign RdBusy[k]                  = rbusy;
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the multi-cycle and pipelined CPU datapaths. It provides NUM_RD combinational read ports and two write ports: port 0 for ALU writeback and port 1 for load/multi-cycle writeback. It has optional write-to-read bypass and a per-register busy scoreboard with an outstanding-reservation counter, which the control unit uses for stall decisions. Register 0 is hardwired to zero.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W (register 0 included, always zero)
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return stored value only

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high; clears every register, every busy bit and BusyCnt
- RdAddr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- RdData  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- RdBusy  out  NUM_RD  busy flag of the register addressed by each read port
- WrEn0  in  1  write enable, port 0 (ALU writeback)
- WrAddr0  in  ADDR_W  write address, port 0
- WrData0  in  DATA_W  write data, port 0
- WrEn1  in  1  write enable, port 1 (load/multi-cycle writeback); also clears the busy bit of WrAddr1
- WrAddr1  in  ADDR_W  write address, port 1
- WrData1  in  DATA_W  write data, port 1
- RsvEn  in  1  reserve request: sets the busy bit of RsvAddr
- RsvAddr  in  ADDR_W  register to reserve
- RsvAck  out  1  reservation accepted this cycle (combinational)
- BusyCnt  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage: 2**ADDR_W - 1 registers of DATA_W, indices 1..max. Index 0 reads as 0, ignores writes, is never busy, and cannot be reserved (RsvAck=0).
- Write: at the rising edge, a register is updated when WrEnN=1 and WrAddrN!=0.
- Write conflict: if both ports write the same index in the same cycle, port 1 wins. Port 0's data is discarded for that index.
- Busy set: when RsvEn=1, RsvAddr!=0 and busy[RsvAddr]=0, RsvAck=1 and busy[RsvAddr] is set at the edge.
- Double reservation: RsvEn on an already-busy register gives RsvAck=0 and no state change. The requester stalls and retries.
- Busy clear: WrEn1=1 with WrAddr1!=0 clears busy[WrAddr1] at the edge. Port 0 never touches busy bits.
- Simultaneous clear and set, same index: the index is busy after the edge, RsvAck=1 and BusyCnt is unchanged. The reservation is a new one. For this case only, RsvAck ignores the current busy bit.
- BusyCnt: next = current + (set accepted && no clear) - (clear of a busy reg && no set). It saturates neither way, by construction, within 0..2**ADDR_W-1.
- Read, BYPASS=0: RdData = stored[RdAddr]; RdBusy = busy[RdAddr].
- Read, BYPASS=1: port 1 has priority, then port 0, then storage.
  - If WrEn1 && WrAddr1==RdAddr!=0: RdData=WrData1 and RdBusy=0.
  - Else if WrEn0 && WrAddr0==RdAddr!=0: RdData=WrData0 and RdBusy=busy[RdAddr].
  - Else: stored value and busy bit.
- Reads have no side effects; any number of ports may address the same index.

## Timing
- Reset: RST high asynchronously forces all registers to 0, all busy to 0 and BusyCnt=0. While RST is high, RdData reads 0, RdBusy=0 and RsvAck=0. Writes and reservations presented during reset are dropped.
- Reset released mid-operation: the first edge with RST low behaves normally. No reservation survives reset.
- Read latency: 0 cycles, combinational from RdAddr and the write/bypass inputs.
- Write latency: 1 edge. With BYPASS=0 the new value is visible on reads in the cycle after WrEn. With BYPASS=1 it is visible in the same cycle.
- Busy latency: a bit set at edge N reads busy from cycle N onward. A bit cleared at edge N reads clear from cycle N onward, or in the clearing cycle itself when BYPASS=1.
- RsvAck is combinational in the same cycle as RsvEn. The requester treats RsvAck=0 as a stall and holds RsvEn/RsvAddr.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert RST mid-cycle (async), then read r5 -> 0. BusyCnt=0 and all RdBusy=0 while RST is high and after release.
- Write/read and r0: write 0x12345678 to r7 and 0xFFFFFFFF to r0 via port 0. The next cycle reads r7=0x12345678 and r0=0. With BYPASS=1, r7 also reads 0x12345678 in the write cycle.
- Dual-write conflict: port 0 writes 0x1111 to r3 while port 1 writes 0x2222 to r3 in the same cycle -> r3=0x2222 afterwards. Same-cycle bypass read (BYPASS=1) shows 0x2222.
- Scoreboard: reserve r9 -> RsvAck=1, BusyCnt goes 0->1, RdBusy for r9=1. Re-reserve r9 -> RsvAck=0. Port 1 writes 0xABCD to r9 -> busy clears and BusyCnt=0. A port 0 write to r9 while it is busy leaves busy=1.
- Simultaneous set and clear: with r4 busy and BusyCnt=1, in one cycle WrEn1 targets r4 and RsvEn targets r4 -> RsvAck=1, r4 is still busy, BusyCnt=1 and the data is updated.
- Counter fill: reserve r1..r31 on consecutive cycles -> BusyCnt=31. Reserving r0 -> RsvAck=0. Clearing all via port 1 -> BusyCnt=0. Run with NUM_RD=1, 2 and 4, and with BYPASS=0 and 1.
